vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator, successor to the fixed 640x480 sync generator.

---
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counts pixels/lines on a clock-enabled
// pixel clock and emits registered syncs, active-area coordinates and frame strobes.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 128,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 9,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 28,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 10,
  parameter int unsigned FCW      = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  output logic           hsync,
  output logic           vsync,
  output logic           activevideo,
  output logic [CW-1:0]  x_px,
  output logic [CW-1:0]  y_px,
  output logic           line_start,
  output logic           frame_start,
  output logic           end_frame,
  output logic [FCW-1:0] frame_cnt
);

  localparam int unsigned HBLANK = H_FP + H_SYNC + H_BP;
  localparam int unsigned HTOTAL = HBLANK + H_ACTIVE;
  localparam int unsigned VBLANK = V_FP + V_SYNC + V_BP;
  localparam int unsigned VTOTAL = VBLANK + V_ACTIVE;

  if ((64'(1) << CW) < 64'(HTOTAL)) begin : g_h_width_chk
    $error("vga_timing_gen: CW too narrow for HTOTAL");
  end
  if ((64'(1) << CW) < 64'(VTOTAL)) begin : g_v_width_chk
    $error("vga_timing_gen: CW too narrow for VTOTAL");
  end

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;

  logic h_last_c;
  logic v_last_c;
  logic hs_on_c;
  logic vs_on_c;
  logic act_c;
  logic line_first_c;

  // Decode of the current counter position; registered into outputs on ce.
  always_comb begin
    h_last_c     = (hc == CW'(HTOTAL - 1));
    v_last_c     = (vc == CW'(VTOTAL - 1));
    hs_on_c      = (hc >= CW'(H_FP)) && (hc < CW'(H_FP + H_SYNC));
    vs_on_c      = (vc >= CW'(V_FP)) && (vc < CW'(V_FP + V_SYNC));
    act_c        = (hc >= CW'(HBLANK)) && (vc >= CW'(VBLANK));
    line_first_c = act_c && (hc == CW'(HBLANK));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      activevideo <= 1'b0;
      x_px        <= '0;
      y_px        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      end_frame   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      // Strobes drop on every clk without ce; levels simply hold.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      end_frame   <= 1'b0;
      if (ce) begin
        if (h_last_c) begin
          hc <= '0;
          vc <= v_last_c ? '0 : vc + CW'(1);
        end else begin
          hc <= hc + CW'(1);
        end
        hsync       <= hs_on_c ? HS_POL : ~HS_POL;
        vsync       <= vs_on_c ? VS_POL : ~VS_POL;
        activevideo <= act_c;
        x_px        <= act_c ? hc - CW'(HBLANK) : '0;
        y_px        <= act_c ? vc - CW'(VBLANK) : '0;
        line_start  <= line_first_c;
        frame_start <= line_first_c && (vc == CW'(VBLANK));
        end_frame   <= h_last_c && v_last_c;
        if (h_last_c && v_last_c) begin
          frame_cnt <= frame_cnt + FCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x8 raster (active 8x4), with an
// inverted-polarity instance alongside.
module tb_vga_timing_gen;

  localparam int unsigned CW  = 5;
  localparam int unsigned FCW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;

  logic           hs_a, vs_a, av_a, ls_a, fs_a, ef_a;
  logic [CW-1:0]  x_a, y_a;
  logic [FCW-1:0] fc_a;
  logic           hs_b, vs_b, av_b, ls_b, fs_b, ef_b;
  logic [CW-1:0]  x_b, y_b;
  logic [FCW-1:0] fc_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .FCW(FCW)
  ) dut_a (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hs_a), .vsync(vs_a), .activevideo(av_a),
    .x_px(x_a), .y_px(y_a),
    .line_start(ls_a), .frame_start(fs_a), .end_frame(ef_a),
    .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .FCW(FCW)
  ) dut_b (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hs_b), .vsync(vs_b), .activevideo(av_b),
    .x_px(x_b), .y_px(y_b),
    .line_start(ls_b), .frame_start(fs_b), .end_frame(ef_b),
    .frame_cnt(fc_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    logic       hs, vs, av;
    logic [4:0] x, y;
    logic       ls, fs, ef;
    logic [1:0] fc;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] pack_a();
    return {hs_a, vs_a, av_a, x_a, y_a, ls_a, fs_a, ef_a, fc_a};
  endfunction

  function automatic logic [17:0] pack_b();
    return {hs_b, vs_b, av_b, x_b, y_b, ls_b, fs_b, ef_b, fc_b};
  endfunction

  // Expected outputs after n ce edges (count c = n-1), ce_now = ce on this clk.
  function automatic logic [17:0] model(input int n, input bit ce_now);
    int c, hc, vc;
    logic hs, vs, av, ls, fs, ef;
    logic [4:0] x, y;
    logic [1:0] fc;
    c  = n - 1;
    hc = c % 16;
    vc = (c / 16) % 8;
    hs = !(hc >= 2 && hc < 5);
    vs = !(vc >= 1 && vc < 3);
    av = (hc >= 8) && (vc >= 4);
    x  = av ? 5'(hc - 8) : 5'd0;
    y  = av ? 5'(vc - 4) : 5'd0;
    ls = ce_now && av && (hc == 8);
    fs = ls && (vc == 4);
    ef = ce_now && (hc == 15) && (vc == 7);
    fc = 2'((n / 128) % 4);
    return {hs, vs, av, x, y, ls, fs, ef, fc};
  endfunction

  task automatic do_reset();
    ce = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int vi;
    int av_cnt, hs_low, vs_low, last_fs;
    logic [17:0] exp;

    vecs[0]  = '{1,   1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{3,   1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{5,   1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{6,   1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{17,  1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{48,  1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{49,  1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{73,  1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{74,  1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{80,  1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{81,  1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{89,  1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{128, 1'b1, 1'b1, 1'b1, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[13] = '{129, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[14] = '{201, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[15] = '{256, 1'b1, 1'b1, 1'b1, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[16] = '{384, 1'b1, 1'b1, 1'b1, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 2'd3};
    vecs[17] = '{512, 1'b1, 1'b1, 1'b1, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[18] = '{513, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset state
    #1;
    do_reset();
    chk("reset_a", 32'(pack_a()), 32'(18'b1_1_0_00000_00000_0_0_0_00));
    chk("reset_b", 32'(pack_b()), 32'(18'b0_0_0_00000_00000_0_0_0_00));

    // Free-running ce=1 against the vector table
    ce = 1'b1;
    vi = 0;
    av_cnt = 0;
    hs_low = 0;
    vs_low = 0;
    for (int k = 1; k <= 513; k++) begin
      tick();
      if (k <= 128 && av_a) av_cnt++;
      if (k <= 16 && !hs_a) hs_low++;
      if (k <= 128 && !vs_a) vs_low++;
      if (vi < 19 && vecs[vi].k == k) begin
        chk($sformatf("vec%0d_a", vi), 32'(pack_a()),
            32'({vecs[vi].hs, vecs[vi].vs, vecs[vi].av, vecs[vi].x, vecs[vi].y,
                 vecs[vi].ls, vecs[vi].fs, vecs[vi].ef, vecs[vi].fc}));
        chk($sformatf("vec%0d_b_sync", vi), 32'({hs_b, vs_b}), 32'({~vecs[vi].hs, ~vecs[vi].vs}));
        vi++;
      end
    end
    chk("active_count", 32'(av_cnt), 32'd32);
    chk("hsync_low_count", 32'(hs_low), 32'd3);
    chk("vsync_low_count", 32'(vs_low), 32'd32);

    // ce toggling 1/0: strobes one clk wide, levels held on ce=0
    do_reset();
    last_fs = 0;
    for (int j = 1; j <= 600; j++) begin
      ce = (j % 2) == 1;
      tick();
      exp = model((j + 1) / 2, ce);
      chk($sformatf("toggle%0d_a", j), 32'(pack_a()), 32'(exp));
      chk($sformatf("toggle%0d_b_sync", j), 32'({hs_b, vs_b}), 32'({~exp[17], ~exp[16]}));
      if (fs_a === 1'b1) begin
        if (last_fs != 0) chk("frame_period", 32'(j - last_fs), 32'd256);
        last_fs = j;
      end
    end
    chk("toggle_saw_frame", 32'(last_fs), 32'd401);

    // Async reset in mid-frame at hc=10, vc=5 of the second frame
    do_reset();
    ce = 1'b1;
    for (int k = 1; k <= 218; k++) tick();
    chk("pre_reset", 32'(pack_a()), 32'({1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 2'd1}));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_a", 32'(pack_a()), 32'(18'b1_1_0_00000_00000_0_0_0_00));
    chk("async_reset_b", 32'({hs_b, vs_b, fc_b}), 32'(4'b0000));
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 73; k++) begin
      tick();
      chk($sformatf("restart%0d", k), 32'(pack_a()), 32'(model(k, 1'b1)));
    end
    chk("restart_first_active", 32'({av_a, fs_a, x_a, y_a}), 32'({1'b1, 1'b1, 5'd0, 5'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
